// File: rtl/prio_intr_pkg.sv
// Shared types and helpers for the priority interrupt controller.
package prio_intr_pkg;

  // Request handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } state_e;

  // Widest supported channel count; the encoder zero-extends narrower inputs.
  localparam int MAX_CH = 64;

  // Highest-set-bit result: index plus a flag saying any bit was set.
  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
  } hsb_t;

  function automatic hsb_t highest_set(input logic [MAX_CH-1:0] v);
    hsb_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = 6'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_intr_ctrl_prio_enc.sv
// N-input combinational priority encoder; bit N-1 has highest priority.
module prio_enc
  import prio_intr_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  hsb_t hsb;

  // Reuse the package scan so both encoders share one definition of priority.
  always_comb begin
    hsb   = highest_set(MAX_CH'(req));
    idx   = W'(hsb.idx);
    valid = hsb.valid;
  end

endmodule

// File: rtl/prio_intr_ctrl.sv
// Clocked priority interrupt controller: latches falling-edge requests,
// masks them, tracks in-service levels and hands the CPU a vector through
// a one-cycle ack handshake. Build option PRIO_INTR_AUTO_EOI_EN drops
// in-service tracking (ack never sets isr, eoi is ignored).
module prio_intr_ctrl
  import prio_intr_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic [N-1:0] ireq_,
  input  logic         ei_,
  input  logic         mask_we,
  input  logic [N-1:0] mask_d,
  input  logic         ack,
  input  logic         eoi,
  input  logic         oe_,
  output logic         intr_,
  output logic [W-1:0] vec,
  output logic         eo_,
  output logic [N-1:0] pend,
  output logic [N-1:0] isr
);

  logic [N-1:0] hist_q, hist_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] isr_q, isr_d;
  logic [N-1:0] mask_reg_q, mask_reg_d;
  logic [W-1:0] vec_q, vec_d;
  logic         intr_q, intr_d;
  state_e       state_q, state_d;

  logic [N-1:0] elig;
  logic [N-1:0] fell;
  logic [W-1:0] hp;
  logic         hp_v;
  logic         go;
  logic         take;

  assign elig = pend_q & ~mask_reg_q;
  assign fell = hist_q & ~ireq_;

  prio_enc #(.N(N), .W(W)) u_elig_enc (
    .req   (elig),
    .idx   (hp),
    .valid (hp_v)
  );

`ifdef PRIO_INTR_AUTO_EOI_EN
  assign go = hp_v && !ei_;
`else
  logic [W-1:0] hs;
  logic         hs_v;

  prio_enc #(.N(N), .W(W)) u_isr_enc (
    .req   (isr_q),
    .idx   (hs),
    .valid (hs_v)
  );

  assign go = hp_v && (!hs_v || (hp > hs)) && !ei_;
`endif

  // Next-state logic: handshake FSM, pending/in-service bookkeeping, mask and edge history.
  always_comb begin
    state_d    = state_q;
    intr_d     = 1'b1;
    vec_d      = vec_q;
    take       = 1'b0;
    hist_d     = ireq_;
    mask_reg_d = mask_we ? mask_d : mask_reg_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = REQ;
          intr_d  = 1'b0;
        end
      end
      REQ: begin
        if (go && ack) begin
          state_d = HOLD;
          take    = 1'b1;
          vec_d   = hp;
        end else if (!go) begin
          state_d = IDLE;
        end else begin
          intr_d = 1'b0;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A fresh edge on the channel being acked re-posts it, so set after clear.
    pend_d = pend_q;
    if (take) pend_d[hp] = 1'b0;
    pend_d = pend_d | fell;

`ifdef PRIO_INTR_AUTO_EOI_EN
    isr_d = '0;
`else
    // eoi retires the old top level before the newly acked level is recorded.
    isr_d = isr_q;
    if (eoi && hs_v) isr_d[hs] = 1'b0;
    if (take) isr_d[hp] = 1'b1;
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      hist_q     <= '1;
      pend_q     <= '0;
      isr_q      <= '0;
      mask_reg_q <= '1;
      vec_q      <= '0;
      intr_q     <= 1'b1;
      state_q    <= IDLE;
    end else begin
      hist_q     <= hist_d;
      pend_q     <= pend_d;
      isr_q      <= isr_d;
      mask_reg_q <= mask_reg_d;
      vec_q      <= vec_d;
      intr_q     <= intr_d;
      state_q    <= state_d;
    end
  end

  assign intr_ = intr_q;
  assign pend  = pend_q;
  assign isr   = isr_q;
  assign eo_   = ei_ | hp_v;
  assign vec   = oe_ ? 'z : vec_q;

endmodule

// File: tb/tb_prio_intr_ctrl.sv
// Self-checking bench for prio_intr_ctrl (default build, N=8).
module tb_prio_intr_ctrl;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_;
  logic [N-1:0] ireq_;
  logic         ei_;
  logic         mask_we;
  logic [N-1:0] mask_d;
  logic         ack;
  logic         eoi;
  logic         oe_;
  logic         intr_;
  wire  [W-1:0] vec;
  logic         eo_;
  logic [N-1:0] pend;
  logic [N-1:0] isr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [N-1:0] m_hist, m_pend, m_isr, m_mask;
  logic [W-1:0] m_vec;
  logic         m_intr;
  int           m_phase;  // 0 waiting, 1 interrupt raised, 2 post-ack cooldown

  prio_intr_ctrl #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_    (rst_),
    .ireq_   (ireq_),
    .ei_     (ei_),
    .mask_we (mask_we),
    .mask_d  (mask_d),
    .ack     (ack),
    .eoi     (eoi),
    .oe_     (oe_),
    .intr_   (intr_),
    .vec     (vec),
    .eo_     (eo_),
    .pend    (pend),
    .isr     (isr)
  );

  always #5 clk = ~clk;

  function automatic int top_bit(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_step();
    logic [N-1:0] fell, elig, np, ni;
    int hp, hs;
    bit go;
    if (!rst_) begin
      m_hist = '1; m_pend = '0; m_isr = '0; m_mask = '1;
      m_vec = '0; m_intr = 1'b1; m_phase = 0;
    end else begin
      fell = m_hist & ~ireq_;
      elig = m_pend & ~m_mask;
      hp   = top_bit(elig);
      hs   = top_bit(m_isr);
      go   = (hp >= 0) && (hp > hs) && !ei_;
      np   = m_pend;
      ni   = m_isr;
      if (eoi && hs >= 0) ni[hs] = 1'b0;
      if (m_phase == 0) begin
        m_intr = !go;
        if (go) m_phase = 1;
      end else if (m_phase == 1) begin
        if (go && ack) begin
          np[hp]  = 1'b0;
          ni[hp]  = 1'b1;
          m_vec   = W'(hp);
          m_intr  = 1'b1;
          m_phase = 2;
        end else if (!go) begin
          m_intr  = 1'b1;
          m_phase = 0;
        end else begin
          m_intr = 1'b0;
        end
      end else begin
        m_intr  = 1'b1;
        m_phase = 0;
      end
      m_pend = np | fell;
      m_isr  = ni;
      m_hist = ireq_;
      if (mask_we) m_mask = mask_d;
    end
  endtask

  // One clock: advance model, take the edge, sample #1 later, drop pulses.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; ireq_ = '1; ei_ = 1'b0; mask_we = 1'b0; mask_d = '0;
    ack = 1'b0; eoi = 1'b0; oe_ = 1'b0;
    cyc(); cyc();
    vectors++; if (intr_ !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_intr: got %b want 1", intr_); end
    vectors++; if (pend !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_pend: got %h want 00", pend); end
    vectors++; if (isr !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_isr: got %h want 00", isr); end
    vectors++; if (vec !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_vec: got %b want 000", vec); end
    vectors++; if (eo_ !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_eo: got %b want 0", eo_); end
    rst_ = 1'b1;
  endtask

  task automatic test_single();
    mask_we = 1'b1; mask_d = 8'h00; cyc();
    ireq_[5] = 1'b0; cyc();
    vectors++; if (pend !== 8'h20) begin miscompares++; $display("[TB] FAIL single_pend: got %h want 20", pend); end
    vectors++; if (intr_ !== 1'b1) begin miscompares++; $display("[TB] FAIL single_intr_e0: got %b want 1", intr_); end
    cyc();
    vectors++; if (intr_ !== 1'b0) begin miscompares++; $display("[TB] FAIL single_intr_e1: got %b want 0", intr_); end
    ack = 1'b1; cyc();
    vectors++; if (vec !== 3'b101) begin miscompares++; $display("[TB] FAIL single_vec: got %b want 101", vec); end
    vectors++; if (pend !== 8'h00) begin miscompares++; $display("[TB] FAIL single_pend_clr: got %h want 00", pend); end
    vectors++; if (isr !== 8'h20) begin miscompares++; $display("[TB] FAIL single_isr: got %h want 20", isr); end
    vectors++; if (intr_ !== 1'b1) begin miscompares++; $display("[TB] FAIL single_intr_ack: got %b want 1", intr_); end
    cyc();
    vectors++; if (intr_ !== 1'b1) begin miscompares++; $display("[TB] FAIL single_intr_hold: got %b want 1", intr_); end
    ireq_[5] = 1'b1;
  endtask

  task automatic test_nesting();
    ireq_[3] = 1'b0; cyc(); cyc(); cyc();
    vectors++; if (intr_ !== 1'b1) begin miscompares++; $display("[TB] FAIL nest_low_blocked: got %b want 1", intr_); end
    vectors++; if (pend !== 8'h08) begin miscompares++; $display("[TB] FAIL nest_pend3: got %h want 08", pend); end
    ireq_[7] = 1'b0; cyc(); cyc();
    vectors++; if (intr_ !== 1'b0) begin miscompares++; $display("[TB] FAIL nest_high_intr: got %b want 0", intr_); end
    ack = 1'b1; cyc();
    vectors++; if (vec !== 3'b111) begin miscompares++; $display("[TB] FAIL nest_vec7: got %b want 111", vec); end
    vectors++; if (isr !== 8'hA0) begin miscompares++; $display("[TB] FAIL nest_isr: got %h want a0", isr); end
    eoi = 1'b1; cyc();
    vectors++; if (isr !== 8'h20) begin miscompares++; $display("[TB] FAIL nest_eoi1: got %h want 20", isr); end
    eoi = 1'b1; cyc();
    vectors++; if (isr !== 8'h00) begin miscompares++; $display("[TB] FAIL nest_eoi2: got %h want 00", isr); end
    cyc();
    vectors++; if (intr_ !== 1'b0) begin miscompares++; $display("[TB] FAIL nest_ch3_intr: got %b want 0", intr_); end
    ack = 1'b1; cyc();
    vectors++; if (vec !== 3'b011) begin miscompares++; $display("[TB] FAIL nest_vec3: got %b want 011", vec); end
    eoi = 1'b1; cyc();
    ireq_[3] = 1'b1; ireq_[7] = 1'b1; cyc();
  endtask

  task automatic test_back_to_back();
    ireq_[2] = 1'b0; ireq_[6] = 1'b0; cyc();
    vectors++; if (pend !== 8'h44) begin miscompares++; $display("[TB] FAIL b2b_pend: got %h want 44", pend); end
    cyc();
    ack = 1'b1; cyc();
    vectors++; if (vec !== 3'b110) begin miscompares++; $display("[TB] FAIL b2b_vec6: got %b want 110", vec); end
    vectors++; if (pend !== 8'h04) begin miscompares++; $display("[TB] FAIL b2b_pend2: got %h want 04", pend); end
    eoi = 1'b1; cyc(); cyc();
    vectors++; if (intr_ !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_intr2: got %b want 0", intr_); end
    ack = 1'b1; cyc();
    vectors++; if (vec !== 3'b010) begin miscompares++; $display("[TB] FAIL b2b_vec2: got %b want 010", vec); end
    vectors++; if (isr !== 8'h04) begin miscompares++; $display("[TB] FAIL b2b_isr: got %h want 04", isr); end
    eoi = 1'b1; cyc();
    ireq_ = '1; cyc();
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_d = 8'h10; cyc();
    ireq_[4] = 1'b0; cyc(); cyc();
    vectors++; if (pend !== 8'h10) begin miscompares++; $display("[TB] FAIL mask_pend: got %h want 10", pend); end
    vectors++; if (intr_ !== 1'b1) begin miscompares++; $display("[TB] FAIL mask_intr: got %b want 1", intr_); end
    vectors++; if (eo_ !== 1'b0) begin miscompares++; $display("[TB] FAIL mask_eo: got %b want 0", eo_); end
    mask_we = 1'b1; mask_d = 8'h00; cyc(); cyc();
    vectors++; if (intr_ !== 1'b0) begin miscompares++; $display("[TB] FAIL unmask_intr: got %b want 0", intr_); end
    vectors++; if (eo_ !== 1'b1) begin miscompares++; $display("[TB] FAIL unmask_eo: got %b want 1", eo_); end
    ack = 1'b1; cyc();
    vectors++; if (vec !== 3'b100) begin miscompares++; $display("[TB] FAIL mask_vec4: got %b want 100", vec); end
    eoi = 1'b1; cyc();
    ireq_[4] = 1'b1; cyc();
  endtask

  task automatic test_cascade();
    ei_ = 1'b1; ireq_[1] = 1'b0; cyc(); cyc();
    vectors++; if (pend !== 8'h02) begin miscompares++; $display("[TB] FAIL casc_pend: got %h want 02", pend); end
    vectors++; if (intr_ !== 1'b1) begin miscompares++; $display("[TB] FAIL casc_intr: got %b want 1", intr_); end
    vectors++; if (eo_ !== 1'b1) begin miscompares++; $display("[TB] FAIL casc_eo: got %b want 1", eo_); end
    ack = 1'b1; cyc();
    vectors++; if (isr !== 8'h00) begin miscompares++; $display("[TB] FAIL casc_ack_isr: got %h want 00", isr); end
    vectors++; if (pend !== 8'h02) begin miscompares++; $display("[TB] FAIL casc_ack_pend: got %h want 02", pend); end
    oe_ = 1'b1; #1;
    vectors++; if (vec === 3'b100) begin miscompares++; $display("[TB] FAIL casc_vec_released: got %b want not driven", vec); end
    oe_ = 1'b0; #1;
    vectors++; if (vec !== 3'b100) begin miscompares++; $display("[TB] FAIL casc_vec_held: got %b want 100", vec); end
  endtask

  task automatic test_reset_in_req();
    ei_ = 1'b0; cyc();
    vectors++; if (intr_ !== 1'b0) begin miscompares++; $display("[TB] FAIL rreq_intr: got %b want 0", intr_); end
    rst_ = 1'b0; ack = 1'b1; cyc();
    vectors++; if (pend !== 8'h00) begin miscompares++; $display("[TB] FAIL rreq_pend: got %h want 00", pend); end
    vectors++; if (isr !== 8'h00) begin miscompares++; $display("[TB] FAIL rreq_isr: got %h want 00", isr); end
    vectors++; if (intr_ !== 1'b1) begin miscompares++; $display("[TB] FAIL rreq_intr_rst: got %b want 1", intr_); end
    vectors++; if (vec !== 3'd0) begin miscompares++; $display("[TB] FAIL rreq_vec: got %b want 000", vec); end
    rst_ = 1'b1; ireq_ = '1; cyc();
  endtask

  task automatic test_random();
    rst_ = 1'b0; cyc(); rst_ = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        if (ireq_[b]) ireq_[b] = ($urandom_range(0, 7) != 0);
        else          ireq_[b] = ($urandom_range(0, 2) == 0);
      end
      ei_     = ($urandom_range(0, 9) == 0);
      mask_we = ($urandom_range(0, 19) == 0);
      mask_d  = N'($urandom & $urandom & $urandom);
      ack     = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 6) == 0);
      oe_     = ($urandom_range(0, 3) == 0);
      rst_    = ($urandom_range(0, 149) != 0);
      cyc();
      vectors++; if (intr_ !== m_intr) begin miscompares++; $display("[TB] FAIL rnd_intr c=%0d: got %b want %b", c, intr_, m_intr); end
      vectors++; if (pend !== m_pend) begin miscompares++; $display("[TB] FAIL rnd_pend c=%0d: got %h want %h", c, pend, m_pend); end
      vectors++; if (isr !== m_isr) begin miscompares++; $display("[TB] FAIL rnd_isr c=%0d: got %h want %h", c, isr, m_isr); end
      vectors++; if (eo_ !== (ei_ | ((m_pend & ~m_mask) != 0))) begin miscompares++; $display("[TB] FAIL rnd_eo c=%0d: got %b", c, eo_); end
      if (!oe_) begin
        vectors++; if (vec !== m_vec) begin miscompares++; $display("[TB] FAIL rnd_vec c=%0d: got %b want %b", c, vec, m_vec); end
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single();
    test_nesting();
    test_back_to_back();
    test_mask();
    test_cascade();
    test_reset_in_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
